// File: rtl/dcm_sup_pkg.sv
// Shared types and constants for the DCM lock supervisor.
package dcm_sup_pkg;

    typedef enum logic [1:0] {HOLD, WAIT, SETTLE, RUN} state_e;

    localparam int SYNC_STAGES  = 2;
    localparam int BLANK_CYCLES = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, resets to 0.
module sync_2ff
    import dcm_sup_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/dcm_lock_supervisor.sv
// Sequences DCM reset, waits for a stable LOCKED and only then releases the system reset.
// state  | meaning
// HOLD   | dcm_rst asserted for RST_CYCLES
// WAIT   | dcm_rst released, waiting for lock (first BLANK_CYCLES ignore stale lock)
// SETTLE | lock seen, requiring SETTLE_CYCLES consecutive locked cycles
// RUN    | system reset released, lock_ok asserted
module dcm_lock_supervisor
    import dcm_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 1000000,
    parameter int SETTLE_CYCLES = 16,
    parameter int RETRY_W       = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               dcm_locked_i,
    output logic               dcm_rst_o,
    output logic               sys_rst_o,
    output logic               lock_ok_o,
    output logic               lost_lock_o,
    output logic [RETRY_W-1:0] retry_count_o
);

    localparam int CNT_W = $clog2(max3(LOCK_TIMEOUT, SETTLE_CYCLES, RST_CYCLES)) + 1;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   BLANK_END   = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = '1;

    logic               lk;
    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [RETRY_W-1:0] retry_q;
    logic               dcm_rst_q;
    logic               sys_rst_q;
    logic               lock_ok_q;
    logic               lost_lock_q;

    function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
        return (v == RETRY_MAX) ? v : v + RETRY_ONE;
    endfunction

    sync_2ff u_sync_locked (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (dcm_locked_i),
        .q_o   (lk)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            retry_q     <= '0;
            dcm_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            lock_ok_q   <= 1'b0;
            lost_lock_q <= 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == RST_LAST) begin
                        state_q   <= WAIT;
                        cnt_q     <= '0;
                        dcm_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                WAIT: begin
                    // A lock seen on the timeout cycle still counts as a lock.
                    if (cnt_q >= BLANK_END && lk) begin
                        state_q <= SETTLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TO_LAST) begin
                        state_q   <= HOLD;
                        cnt_q     <= '0;
                        dcm_rst_q <= 1'b1;
                        retry_q   <= sat_inc(retry_q);
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                SETTLE: begin
                    if (!lk) begin
                        state_q   <= HOLD;
                        cnt_q     <= '0;
                        dcm_rst_q <= 1'b1;
                        retry_q   <= sat_inc(retry_q);
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_q   <= RUN;
                        cnt_q     <= '0;
                        sys_rst_q <= 1'b0;
                        lock_ok_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RUN: begin
                    if (!lk) begin
                        state_q     <= HOLD;
                        cnt_q       <= '0;
                        dcm_rst_q   <= 1'b1;
                        sys_rst_q   <= 1'b1;
                        lock_ok_q   <= 1'b0;
                        lost_lock_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= HOLD;
                    cnt_q     <= '0;
                    dcm_rst_q <= 1'b1;
                    sys_rst_q <= 1'b1;
                    lock_ok_q <= 1'b0;
                end
            endcase
        end
    end

    assign dcm_rst_o     = dcm_rst_q;
    assign sys_rst_o     = sys_rst_q;
    assign lock_ok_o     = lock_ok_q;
    assign lost_lock_o   = lost_lock_q;
    assign retry_count_o = retry_q;

endmodule
